// File: rtl/ram_dsp_mac.sv
// Neuron weight store and unsigned multiply-accumulate datapath.
// A 2**ADDR_W-word RAM with a registered read port supplies operand B of a 3-stage MAC.
module ram_dsp_mac #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned ACC_W  = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] x,
  input  logic              sclr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ACC_W-1:0]  p
);

  localparam int unsigned DEPTH  = 2**ADDR_W;
  localparam int unsigned PROD_W = 2*DATA_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_r;
  logic [PROD_W-1:0] m_r;

  // Every word is reset so nothing undefined can ever reach the MAC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-first: a same-address write this edge is only seen by later reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      m_r <= '0;
      p   <= '0;
    end else if (sclr) begin
      a_r <= '0;
      m_r <= '0;
      p   <= '0;
    end else begin
      a_r <= x;
      m_r <= PROD_W'(a_r) * PROD_W'(rd_data);
      p   <= p + ACC_W'(m_r);
    end
  end

endmodule

// File: tb/tb_ram_dsp_mac.sv
// Bench for ram_dsp_mac: hand-derived vector table, multi-cycle corner sequences
// and a randomized phase checked against a behavioural model through a scoreboard queue.
module tb_ram_dsp_mac;

  logic        clk;
  logic        rst_n;
  logic        wr_en, rd_en, sclr;
  logic [1:0]  wr_addr, rd_addr;
  logic [15:0] wr_data, x, rd_data;
  logic [47:0] p;

  logic        w_wr_en, w_rd_en, w_sclr;
  logic [1:0]  w_wr_addr, w_rd_addr;
  logic [23:0] w_wr_data, w_x, w_rd_data;
  logic [47:0] w_p;

  int n_checks = 0;
  int n_fail   = 0;

  ram_dsp_mac #(.DATA_W(16), .ADDR_W(2), .ACC_W(48)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .x(x), .sclr(sclr), .rd_data(rd_data), .p(p)
  );

  // Wider operands let the 48-bit accumulator wrap within a couple of pairs.
  ram_dsp_mac #(.DATA_W(24), .ADDR_W(2), .ACC_W(48)) dut_w (
    .clk(clk), .rst_n(rst_n), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .rd_en(w_rd_en), .rd_addr(w_rd_addr), .x(w_x), .sclr(w_sclr), .rd_data(w_rd_data), .p(w_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [15:0] x;
    logic        sclr;
    logic [15:0] exp_rd;
    logic [47:0] exp_p;
  } vec_t;

  typedef struct {
    logic [15:0] rd;
    logic [47:0] p;
  } exp_t;

  vec_t tv [34];
  exp_t sbq [$];

  // Behavioural model state for the randomized phase.
  logic [15:0] mem_m [4];
  logic [15:0] rd_m;
  logic [31:0] stage_a_prod, stage_m_prod;
  logic [47:0] p_m;

  function automatic vec_t mk(input logic we, input logic [1:0] wa, input logic [15:0] wd,
                              input logic re, input logic [1:0] ra, input logic [15:0] xv,
                              input logic sc, input logic [15:0] erd, input logic [47:0] ep);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.rd_en = re; v.rd_addr = ra; v.x = xv; v.sclr = sc;
    v.exp_rd = erd; v.exp_p = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wr_en = v.wr_en; wr_addr = v.wr_addr; wr_data = v.wr_data;
    rd_en = v.rd_en; rd_addr = v.rd_addr; x = v.x; sclr = v.sclr;
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      check({name, "_sbq_empty"}, 64'd1, 64'd0);
    end else begin
      e = sbq.pop_front();
      check({name, "_rd"}, 64'(rd_data), 64'(e.rd));
      check({name, "_p"},  64'(p),       64'(e.p));
    end
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0; x = 0; sclr = 0;
    w_wr_en = 0; w_wr_addr = 0; w_wr_data = 0; w_rd_en = 0; w_rd_addr = 0; w_x = 0; w_sclr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Predicts rd_data/p after the coming edge from the inputs currently driven.
  task automatic model_step();
    logic [15:0] new_rd;
    new_rd = rd_en ? mem_m[rd_addr] : rd_m;
    if (wr_en) mem_m[wr_addr] = wr_data;
    if (sclr) begin
      p_m = '0; stage_m_prod = '0; stage_a_prod = '0;
    end else begin
      p_m          = p_m + 48'(stage_m_prod);
      stage_m_prod = stage_a_prod;
      stage_a_prod = 32'(x) * 32'(new_rd);
    end
    rd_m = new_rd;
    sbq.push_back('{rd: rd_m, p: p_m});
  endtask

  initial begin
    // Scenario 1: load weights 1..4, four pairs -> 300
    tv[0]  = mk(1, 0, 1,        0, 0, 0,        0, 0,        0);
    tv[1]  = mk(1, 1, 2,        0, 0, 0,        0, 0,        0);
    tv[2]  = mk(1, 2, 3,        0, 0, 0,        0, 0,        0);
    tv[3]  = mk(1, 3, 4,        0, 0, 0,        0, 0,        0);
    tv[4]  = mk(0, 0, 0,        1, 0, 10,       0, 1,        0);
    tv[5]  = mk(0, 0, 0,        1, 1, 20,       0, 2,        0);
    tv[6]  = mk(0, 0, 0,        1, 2, 30,       0, 3,        10);
    tv[7]  = mk(0, 0, 0,        1, 3, 40,       0, 4,        50);
    tv[8]  = mk(0, 0, 0,        0, 0, 0,        0, 4,        140);
    tv[9]  = mk(0, 0, 0,        0, 0, 0,        0, 4,        300);
    tv[10] = mk(0, 0, 0,        0, 0, 0,        0, 4,        300);
    // Scenario 6: rd_en low, address moves, held weight 4 keeps multiplying
    tv[11] = mk(0, 0, 0,        0, 0, 1,        0, 4,        300);
    tv[12] = mk(0, 0, 0,        0, 1, 2,        0, 4,        300);
    tv[13] = mk(0, 0, 0,        0, 2, 0,        0, 4,        304);
    tv[14] = mk(0, 0, 0,        0, 3, 0,        0, 4,        312);
    tv[15] = mk(0, 0, 0,        0, 0, 0,        1, 4,        0);
    // Scenario 4: sclr after 2nd pair; only 40*4 survives
    tv[16] = mk(0, 0, 0,        1, 0, 10,       0, 1,        0);
    tv[17] = mk(0, 0, 0,        1, 1, 20,       0, 2,        0);
    tv[18] = mk(0, 0, 0,        1, 2, 30,       1, 3,        0);
    tv[19] = mk(0, 0, 0,        1, 3, 40,       0, 4,        0);
    tv[20] = mk(0, 0, 0,        0, 0, 0,        0, 4,        0);
    tv[21] = mk(0, 0, 0,        0, 0, 0,        0, 4,        160);
    tv[22] = mk(0, 0, 0,        0, 0, 0,        0, 4,        160);
    // Scenario 3: read-during-write is read-first; sclr does not disturb RAM
    tv[23] = mk(1, 2, 5,        0, 0, 0,        0, 4,        160);
    tv[24] = mk(1, 2, 9,        1, 2, 0,        0, 5,        160);
    tv[25] = mk(0, 0, 0,        1, 2, 0,        0, 9,        160);
    tv[26] = mk(1, 3, 7,        1, 3, 0,        1, 4,        0);
    tv[27] = mk(0, 0, 0,        1, 3, 0,        0, 7,        0);
    // Scenario 2: max operands, two pairs
    tv[28] = mk(1, 0, 16'hFFFF, 0, 0, 0,        0, 7,        0);
    tv[29] = mk(0, 0, 0,        1, 0, 16'hFFFF, 0, 16'hFFFF, 0);
    tv[30] = mk(0, 0, 0,        1, 0, 16'hFFFF, 0, 16'hFFFF, 0);
    tv[31] = mk(0, 0, 0,        0, 0, 0,        0, 16'hFFFF, 48'h0000_FFFE_0001);
    tv[32] = mk(0, 0, 0,        0, 0, 0,        0, 16'hFFFF, 48'h0001_FFFC_0002);
    tv[33] = mk(0, 0, 0,        0, 0, 0,        0, 16'hFFFF, 48'h0001_FFFC_0002);

    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("reset_p",       64'(p),       64'd0);
    check("reset_rd",      64'(rd_data), 64'd0);
    check("reset_w_p",     64'(w_p),     64'd0);
    #11 rst_n = 1'b1;
    tick();

    // 48-bit wrap on the wide-operand instance
    w_wr_en = 1; w_wr_addr = 0; w_wr_data = 24'hFF_FFFF;
    tick();
    w_wr_en = 0; w_rd_en = 1; w_rd_addr = 0; w_x = 24'hFF_FFFF;
    tick();
    check("wrap_rd", 64'(w_rd_data), 64'h00FF_FFFF);
    tick();
    w_rd_en = 0; w_x = 0;
    tick();
    check("wrap_p1", 64'(w_p), 64'h0000_FFFF_FE00_0001);
    tick();
    check("wrap_p2", 64'(w_p), 64'h0000_FFFF_FC00_0002);
    tick();
    check("wrap_hold", 64'(w_p), 64'h0000_FFFF_FC00_0002);

    for (int i = 0; i < 34; i++) begin
      drive(tv[i]);
      sbq.push_back('{rd: tv[i].exp_rd, p: tv[i].exp_p});
      tick();
      pop_check($sformatf("row%0d", i));
    end

    // Scenario 5: async reset between edges with products in flight
    wr_en = 0; sclr = 0; rd_en = 1; rd_addr = 1; x = 16'd3;
    tick();
    rd_addr = 3; x = 16'd5;
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_p",  64'(p),       64'd0);
    check("async_rst_rd", 64'(rd_data), 64'd0);
    idle_inputs();
    @(posedge clk);
    #4 rst_n = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      rd_en = 1; rd_addr = 2'(a);
      tick();
      check($sformatf("rst_ram%0d", a), 64'(rd_data), 64'd0);
    end
    check("rst_p_after", 64'(p), 64'd0);
    rd_en = 0; wr_en = 1; wr_addr = 1; wr_data = 16'd6;
    tick();
    wr_en = 0; rd_en = 1; rd_addr = 1;
    tick();
    check("post_rst_write", 64'(rd_data), 64'd6);

    // Randomized phase from a clean reset against the model
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) mem_m[i] = '0;
    rd_m = '0; stage_a_prod = '0; stage_m_prod = '0; p_m = '0;
    for (int i = 0; i < 80; i++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 16'($urandom);
      rd_en   = ($urandom_range(0, 3) != 0);
      rd_addr = 2'($urandom_range(0, 3));
      x       = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
      sclr    = ($urandom_range(0, 9) == 0);
      model_step();
      tick();
      pop_check($sformatf("rand%0d", i));
    end
    check("sbq_drained", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
